// File: rtl/gray_codec_pipe_pkg.sv
// Shared definitions for the Gray code converter pipeline: mode encodings,
// legal word-width range and a helper used for the elaboration range check.
package gray_codec_pipe_pkg;

    localparam logic MODE_ENC = 1'b0;   // binary -> Gray
    localparam logic MODE_DEC = 1'b1;   // Gray -> binary

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gray_codec_pipe_if.sv
// Handshake bundle for gray_codec_pipe. The slave modport is the converter's
// view, the master modport is the view of whatever feeds and drains it.
// Optional out_parity exists only when GRAY_CODEC_PARITY_EN is defined.
//
// Valid/ready: a word moves across a side on every rising clk edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until that edge; ready may depend combinationally on the far side.
interface gray_codec_pipe_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_mode;
    logic [WIDTH-1:0] out_data;
`ifdef GRAY_CODEC_PARITY_EN
    logic             out_parity;

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_parity
    );
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_parity
    );
`else
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );
`endif
endinterface

// File: rtl/gray_xlate.sv
// Combinational binary/Gray translator. Mode selects the direction; the
// module is stateless so it can be dropped into Gray-pointer FIFOs as well.
module gray_xlate
    import gray_codec_pipe_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] enc;
    logic [WIDTH-1:0] dec;

    // Encode is a single shifted XOR; decode bit i is the XOR of din[WIDTH-1:i],
    // written as a reduction so no bit depends on another output bit.
    always_comb begin
        enc = din ^ (din >> 1);
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = ^(din >> i);
        end
        dout = (mode == MODE_DEC) ? dec : enc;
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage registered binary/Gray converter with valid/ready on both sides.
// Stage 1 captures the input word and its mode; stage 2 holds the converted
// word. Full throughput with no skid buffer: in_ready is combinational from
// out_ready, so at most two words are in flight.
// Optional feature macro: GRAY_CODEC_PARITY_EN adds a registered out_parity.
module gray_codec_pipe
    import gray_codec_pipe_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    gray_codec_pipe_if.slave   bus
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("gray_codec_pipe: WIDTH out of range 2..32");
    end

    logic             s1_valid;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] xl_data;
    logic             s2_load;
    logic             in_fire;

    // Stage 2 can take a word when it is empty or is emptying this cycle;
    // stage 1 can take a word when it is empty or is moving forward.
    assign s2_load     = s1_valid && (!bus.out_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign in_fire     = bus.in_valid && bus.in_ready;

    gray_xlate #(.WIDTH(WIDTH)) u_xlate (
        .mode (s1_mode),
        .din  (s1_data),
        .dout (xl_data)
    );

    // Stage 1: capture an accepted input word, or drain into stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_ENC;
            s1_data  <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_mode  <= bus.in_mode;
            s1_data  <= bus.in_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the converted word; otherwise empty on a downstream take,
    // holding data and mode stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_mode  <= MODE_ENC;
            bus.out_data  <= '0;
        end else if (s2_load) begin
            bus.out_valid <= 1'b1;
            bus.out_mode  <= s1_mode;
            bus.out_data  <= xl_data;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef GRAY_CODEC_PARITY_EN
    logic s1_parity;

    // Parity is always over the binary form: the input for encode, the
    // decoded result for decode.
    assign s1_parity = (s1_mode == MODE_DEC) ? ^xl_data : ^s1_data;

    // Parity register travels with out_data and holds during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_parity <= 1'b0;
        end else if (s2_load) begin
            bus.out_parity <= s1_parity;
        end
    end
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: a WIDTH=3 and a WIDTH=8 instance share
// clock and reset. Inputs change 1 ns after the rising edge; handshakes are
// observed on the falling edge by a monitor feeding the output queue.
module tb_gray_codec_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] d;
        logic       m;
        int         c;
    } rec_t;

    rec_t got_q[$];
    int   acc_q[$];
    logic [7:0] enc_v[256];

    gray_codec_pipe_if #(.WIDTH(3)) bus3 ();
    gray_codec_pipe_if #(.WIDTH(8)) bus8 ();

    gray_codec_pipe #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    gray_codec_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus8.out_valid && bus8.out_ready) begin
                got_q.push_back('{d: bus8.out_data, m: bus8.out_mode, c: cyc});
            end
            if (bus8.in_valid && bus8.in_ready) begin
                acc_q.push_back(cyc);
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word to the 8-bit instance and return once it has transferred.
    task automatic send8(input logic [7:0] d, input logic m);
        bit done = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        bus8.in_mode  = m;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus8.in_ready) done = 1'b1;
            step();
        end
        n_checks++;
        if (!done) $display("FAIL send8_accept timeout word %h", d);
        else n_pass++;
    endtask

    task automatic idle8();
        bus8.in_valid = 1'b0;
        bus8.in_data  = 8'h00;
        bus8.in_mode  = 1'b0;
    endtask

    task automatic wait_got(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < n * 3 + 50 && !ok; k++) begin
            if (got_q.size() >= n) ok = 1'b1;
            else step();
        end
        repeat (4) step();
    endtask

    task automatic clear_q();
        got_q.delete();
        acc_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus8.out_valid); else n_pass++;
        n_checks++; if (bus8.out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", bus8.out_data); else n_pass++;
        n_checks++; if (bus8.out_mode !== 1'b0) $display("FAIL reset_out_mode got %b exp 0", bus8.out_mode); else n_pass++;
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus8.in_ready); else n_pass++;
        n_checks++; if (bus3.out_valid !== 1'b0) $display("FAIL reset3_out_valid got %b exp 0", bus3.out_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL idle_in_ready got %b exp 1", bus8.in_ready); else n_pass++;
        step();
    endtask

    task automatic test_width3();
        bus3.out_ready = 1'b1;
        bus3.in_valid  = 1'b1;
        bus3.in_data   = 3'b110;
        bus3.in_mode   = 1'b0;
        step();
        bus3.in_valid  = 1'b0;
        n_checks++; if (bus3.out_valid !== 1'b0) $display("FAIL w3_enc_early got %b exp 0", bus3.out_valid); else n_pass++;
        step();
        n_checks++; if (bus3.out_valid !== 1'b1) $display("FAIL w3_enc_valid got %b exp 1", bus3.out_valid); else n_pass++;
        n_checks++; if (bus3.out_data !== 3'b101) $display("FAIL w3_enc_data got %b exp 101", bus3.out_data); else n_pass++;
        n_checks++; if (bus3.out_mode !== 1'b0) $display("FAIL w3_enc_mode got %b exp 0", bus3.out_mode); else n_pass++;
        bus3.in_valid  = 1'b1;
        bus3.in_data   = 3'b100;
        bus3.in_mode   = 1'b1;
        step();
        bus3.in_valid  = 1'b0;
        step();
        n_checks++; if (bus3.out_valid !== 1'b1) $display("FAIL w3_dec_valid got %b exp 1", bus3.out_valid); else n_pass++;
        n_checks++; if (bus3.out_data !== 3'b111) $display("FAIL w3_dec_data got %b exp 111", bus3.out_data); else n_pass++;
        n_checks++; if (bus3.out_mode !== 1'b1) $display("FAIL w3_dec_mode got %b exp 1", bus3.out_mode); else n_pass++;
        step();
    endtask

    task automatic test_vectors8();
        logic [7:0] din [4] = '{8'hFF, 8'hAA, 8'h80, 8'h01};
        logic       mdin[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_d[4] = '{8'hAA, 8'hFF, 8'hC0, 8'h01};
        bit ok;
        clear_q();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send8(din[i], mdin[i]);
        idle8();
        wait_got(4, ok);
        n_checks++; if (got_q.size() != 4) $display("FAIL vec_count got %0d exp 4", got_q.size()); else n_pass++;
        if (ok && got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (got_q[i].d !== exp_d[i]) $display("FAIL vec_data[%0d] got %h exp %h", i, got_q[i].d, exp_d[i]); else n_pass++;
                n_checks++; if (got_q[i].m !== mdin[i]) $display("FAIL vec_mode[%0d] got %b exp %b", i, got_q[i].m, mdin[i]); else n_pass++;
                n_checks++; if (got_q[i].c - acc_q[i] != 2) $display("FAIL vec_latency[%0d] got %0d exp 2", i, got_q[i].c - acc_q[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_d[4] = '{8'h01, 8'h03, 8'h02, 8'h06};
        bit ok;
        clear_q();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in_mode   = 1'b0;
        bus8.in_data   = 8'h01;
        @(negedge clk);
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL stall_rdy_w1 got %b exp 1", bus8.in_ready); else n_pass++;
        step();
        bus8.in_data = 8'h02;
        @(negedge clk);
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL stall_rdy_w2 got %b exp 1", bus8.in_ready); else n_pass++;
        step();
        bus8.in_data = 8'h03;
        @(negedge clk);
        n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL stall_rdy_w3 got %b exp 0", bus8.in_ready); else n_pass++;
        n_checks++; if (bus8.out_valid !== 1'b1) $display("FAIL stall_out_valid got %b exp 1", bus8.out_valid); else n_pass++;
        n_checks++; if (bus8.out_data !== 8'h01) $display("FAIL stall_out_data got %h exp 01", bus8.out_data); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL stall_rdy_hold got %b exp 0", bus8.in_ready); else n_pass++;
        n_checks++; if (bus8.out_data !== 8'h01) $display("FAIL stall_data_hold got %h exp 01", bus8.out_data); else n_pass++;
        n_checks++; if (bus8.out_mode !== 1'b0) $display("FAIL stall_mode_hold got %b exp 0", bus8.out_mode); else n_pass++;
        step();
        bus8.out_ready = 1'b1;
        send8(8'h03, 1'b0);
        send8(8'h04, 1'b0);
        idle8();
        wait_got(4, ok);
        n_checks++; if (got_q.size() != 4) $display("FAIL stall_count got %0d exp 4", got_q.size()); else n_pass++;
        if (ok && got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (got_q[i].d !== exp_d[i]) $display("FAIL stall_order[%0d] got %h exp %h", i, got_q[i].d, exp_d[i]); else n_pass++;
                n_checks++; if (got_q[i].c != got_q[0].c + i) $display("FAIL stall_gap[%0d] got %0d exp %0d", i, got_q[i].c, got_q[0].c + i); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] din[16] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h08,
                                8'h55, 8'h7F, 8'hF0, 8'h88, 8'h3C, 8'hC3, 8'hFE, 8'h81};
        logic [7:0] exp_d[16] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h03, 8'h02, 8'h08, 8'h0F,
                                  8'h7F, 8'h55, 8'h88, 8'hF0, 8'h22, 8'h82, 8'h81, 8'hFE};
        bit ok;
        clear_q();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send8(din[i], 1'(i % 2));
        idle8();
        wait_got(16, ok);
        n_checks++; if (got_q.size() != 16) $display("FAIL b2b_count got %0d exp 16", got_q.size()); else n_pass++;
        if (ok && got_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (got_q[i].d !== exp_d[i]) $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i].d, exp_d[i]); else n_pass++;
                n_checks++; if (got_q[i].m !== 1'(i % 2)) $display("FAIL b2b_mode[%0d] got %b exp %b", i, got_q[i].m, 1'(i % 2)); else n_pass++;
                n_checks++; if (got_q[i].c - acc_q[i] != 2) $display("FAIL b2b_latency[%0d] got %0d exp 2", i, got_q[i].c - acc_q[i]); else n_pass++;
                n_checks++; if (got_q[i].c != got_q[0].c + i) $display("FAIL b2b_rate[%0d] got %0d exp %0d", i, got_q[i].c, got_q[0].c + i); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        clear_q();
        bus8.out_ready = 1'b0;
        send8(8'h10, 1'b1);
        send8(8'h20, 1'b1);
        idle8();
        n_checks++; if (bus8.out_data !== 8'h1F) $display("FAIL flush_pre_data got %h exp 1f", bus8.out_data); else n_pass++;
        n_checks++; if (bus8.out_mode !== 1'b1) $display("FAIL flush_pre_mode got %b exp 1", bus8.out_mode); else n_pass++;
        n_checks++; if (bus8.in_ready !== 1'b0) $display("FAIL flush_pre_ready got %b exp 0", bus8.in_ready); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus8.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", bus8.out_valid); else n_pass++;
        n_checks++; if (bus8.out_data !== 8'h00) $display("FAIL flush_out_data got %h exp 00", bus8.out_data); else n_pass++;
        n_checks++; if (bus8.out_mode !== 1'b0) $display("FAIL flush_out_mode got %b exp 0", bus8.out_mode); else n_pass++;
        n_checks++; if (bus8.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", bus8.in_ready); else n_pass++;
        step();
        rst = 1'b0;
        step();
        clear_q();
        bus8.out_ready = 1'b1;
        send8(8'h33, 1'b0);
        idle8();
        wait_got(1, ok);
        n_checks++; if (got_q.size() != 1) $display("FAIL flush_after_count got %0d exp 1", got_q.size()); else n_pass++;
        if (ok && got_q.size() == 1) begin
            n_checks++; if (got_q[0].d !== 8'h2A) $display("FAIL flush_after_data got %h exp 2a", got_q[0].d); else n_pass++;
            n_checks++; if (got_q[0].c - acc_q[0] != 2) $display("FAIL flush_after_latency got %0d exp 2", got_q[0].c - acc_q[0]); else n_pass++;
        end
    endtask

    task automatic test_roundtrip();
        bit ok;
        int ones;
        clear_q();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) send8(8'(i), 1'b0);
        idle8();
        wait_got(256, ok);
        n_checks++; if (got_q.size() != 256) $display("FAIL rt_enc_count got %0d exp 256", got_q.size()); else n_pass++;
        if (ok && got_q.size() == 256) begin
            for (int i = 0; i < 256; i++) enc_v[i] = got_q[i].d;
            for (int i = 0; i < 256; i++) begin
                ones = $countones(enc_v[i] ^ enc_v[(i + 1) % 256]);
                n_checks++; if (ones != 1) $display("FAIL rt_adjacent[%0d] got %0d bits exp 1", i, ones); else n_pass++;
            end
            clear_q();
            for (int i = 0; i < 256; i++) send8(enc_v[i], 1'b1);
            idle8();
            wait_got(256, ok);
            n_checks++; if (got_q.size() != 256) $display("FAIL rt_dec_count got %0d exp 256", got_q.size()); else n_pass++;
            if (ok && got_q.size() == 256) begin
                for (int i = 0; i < 256; i++) begin
                    n_checks++; if (got_q[i].d !== 8'(i)) $display("FAIL rt_value[%0d] got %h exp %h", i, got_q[i].d, 8'(i)); else n_pass++;
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus3.in_valid  = 1'b0;
        bus3.in_mode   = 1'b0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_mode   = 1'b0;
        bus8.in_data   = '0;
        bus8.out_ready = 1'b0;

        test_reset();
        test_width3();
        test_vectors8();
        test_stall();
        test_back_to_back();
        test_reset_flush();
        test_roundtrip();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
